// File: rtl/xor_accum_nbit.sv
// ============================================================================
//  Module      : xor_accum_nbit
//  Description : Streaming XOR unit. Emits pairwise a^b results or folds a
//                multi-beat frame into a single XOR result plus beat count.
//                Optional parity output enabled by macro XOR_ACCUM_PARITY_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module xor_accum_nbit #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             mode,
    input  logic             last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
`ifdef XOR_ACCUM_PARITY_EN
    output logic             parity,
`endif
    output logic [CNT_W-1:0] beats
);

    localparam logic [0:0]       S_IDLE     = 1'b0;
    localparam logic [0:0]       S_ACCUM    = 1'b1;
    localparam logic [CNT_W-1:0] c_CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_CNT_MAX  = {CNT_W{1'b1}};

    logic [0:0]       r_state;
    logic [0:0]       w_state_next;
    logic [WIDTH-1:0] r_acc;
    logic [CNT_W-1:0] r_count;
    logic [WIDTH-1:0] r_out;
    logic [CNT_W-1:0] r_beats;
    logic             r_out_valid;

    logic             w_fire;
    logic [WIDTH-1:0] w_acc_base;
    logic [CNT_W-1:0] w_cnt_base;
    logic [WIDTH-1:0] w_acc_xor;
    logic [CNT_W-1:0] w_cnt_inc;
    logic             w_load_out;
    logic [WIDTH-1:0] w_out_next;
    logic [CNT_W-1:0] w_beats_next;
    logic [WIDTH-1:0] w_acc_next;
    logic [CNT_W-1:0] w_cnt_next;
    logic             w_valid_next;

    assign in_ready  = ~r_out_valid | out_ready;
    assign w_fire    = in_valid & in_ready;
    assign out       = r_out;
    assign beats     = r_beats;
    assign out_valid = r_out_valid;

    // An empty (IDLE) accumulator always folds from zero.
    assign w_acc_base = (r_state == S_ACCUM) ? r_acc   : '0;
    assign w_cnt_base = (r_state == S_ACCUM) ? r_count : '0;
    assign w_acc_xor  = w_acc_base ^ a ^ b;
    assign w_cnt_inc  = (w_cnt_base == c_CNT_MAX) ? c_CNT_MAX : w_cnt_base + c_CNT_ONE;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: pairwise beats never disturb the open frame
    always_comb begin
        w_state_next = r_state;
        if (w_fire && mode) begin
            w_state_next = last ? S_IDLE : S_ACCUM;
        end
    end

    // Output / datapath control
    always_comb begin
        w_load_out   = 1'b0;
        w_out_next   = r_out;
        w_beats_next = r_beats;
        w_acc_next   = r_acc;
        w_cnt_next   = r_count;
        if (w_fire) begin
            if (!mode) begin
                w_load_out   = 1'b1;
                w_out_next   = a ^ b;
                w_beats_next = c_CNT_ONE;
            end else if (last) begin
                w_load_out   = 1'b1;
                w_out_next   = w_acc_xor;
                w_beats_next = w_cnt_inc;
                w_acc_next   = '0;
                w_cnt_next   = '0;
            end else begin
                w_acc_next   = w_acc_xor;
                w_cnt_next   = w_cnt_inc;
            end
        end
        // A fresh load wins over a handoff, so back-to-back results never bubble.
        w_valid_next = w_load_out | (r_out_valid & ~out_ready);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_acc       <= '0;
            r_count     <= '0;
            r_out       <= '0;
            r_beats     <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_acc       <= w_acc_next;
            r_count     <= w_cnt_next;
            r_out       <= w_out_next;
            r_beats     <= w_beats_next;
            r_out_valid <= w_valid_next;
        end
    end

`ifdef XOR_ACCUM_PARITY_EN
    logic r_parity;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_parity <= 1'b0;
        end else if (w_load_out) begin
            r_parity <= ^w_out_next;
        end
    end

    assign parity = r_parity;
`endif

endmodule

`default_nettype wire

// File: tb/tb_xor_accum_nbit.sv
// Bench for xor_accum_nbit: directed vector table, corner-case sequences,
// and randomized traffic checked against a frame-list reference model.
`default_nettype none

module tb_xor_accum_nbit;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] a;
    logic [7:0] b;
    logic       mode;
    logic       last;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out;
    logic [7:0] beats;
`ifdef XOR_ACCUM_PARITY_EN
    logic       parity;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    xor_accum_nbit #(.WIDTH(8), .CNT_W(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .mode      (mode),
        .last      (last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
`ifdef XOR_ACCUM_PARITY_EN
        .parity    (parity),
`endif
        .beats     (beats)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       v;
        logic       m;
        logic       l;
        logic [7:0] ea;
        logic [7:0] eb;
        logic       ordy;
        logic       x_valid;
        logic [7:0] x_out;
        logic [7:0] x_beats;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic v, input logic m, input logic l,
                         input logic [7:0] aa, input logic [7:0] bb, input logic ordy);
        in_valid  = v;
        mode      = m;
        last      = l;
        a         = aa;
        b         = bb;
        out_ready = ordy;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_outs(input string tag, input logic v, input logic [7:0] o, input logic [7:0] bt);
        check({tag, ".valid"}, 64'(out_valid), 64'(v));
        check({tag, ".out"},   64'(out),       64'(o));
        check({tag, ".beats"}, 64'(beats),     64'(bt));
`ifdef XOR_ACCUM_PARITY_EN
        check({tag, ".parity"}, 64'(parity), 64'(^o));
`endif
    endtask

    vec_t tbl[10];

    // Reference model: open frame kept as a list of per-beat XORs.
    logic [7:0] frame_q[$];
    logic [7:0] m_out;
    logic [7:0] m_beats;
    logic       m_valid;

    function automatic logic [7:0] fold_frame();
        logic [7:0] r = 8'h00;
        foreach (frame_q[i]) r = r ^ frame_q[i];
        return r;
    endfunction

    initial begin
        tbl[0] = '{1'b1, 1'b0, 1'b0, 8'hA5, 8'h0F, 1'b1, 1'b1, 8'hAA, 8'd1};
        tbl[1] = '{1'b1, 1'b1, 1'b0, 8'h01, 8'h02, 1'b1, 1'b0, 8'hAA, 8'd1};
        tbl[2] = '{1'b1, 1'b1, 1'b0, 8'h04, 8'h08, 1'b1, 1'b0, 8'hAA, 8'd1};
        tbl[3] = '{1'b1, 1'b1, 1'b1, 8'h10, 8'h20, 1'b1, 1'b1, 8'h3F, 8'd3};
        tbl[4] = '{1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h3F, 8'd3};
        tbl[5] = '{1'b1, 1'b1, 1'b1, 8'hFF, 8'h00, 1'b1, 1'b1, 8'hFF, 8'd1};
        tbl[6] = '{1'b1, 1'b1, 1'b0, 8'h01, 8'h00, 1'b1, 1'b0, 8'hFF, 8'd1};
        tbl[7] = '{1'b1, 1'b0, 1'b0, 8'h12, 8'h34, 1'b1, 1'b1, 8'h26, 8'd1};
        tbl[8] = '{1'b1, 1'b1, 1'b1, 8'h02, 8'h00, 1'b1, 1'b1, 8'h03, 8'd2};
        tbl[9] = '{1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h03, 8'd2};

        reset = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
        #1;
        check("reset_in_ready", 64'(in_ready), 64'd1);
        check_outs("reset", 1'b0, 8'h00, 8'h00);
        tick();
        tick();
        reset = 1'b0;
        tick();
        check_outs("post_reset", 1'b0, 8'h00, 8'h00);

        // Directed vectors: pairwise, 3-beat frame, single-beat frame, interleave
        for (int i = 0; i < 10; i++) begin
            drive(tbl[i].v, tbl[i].m, tbl[i].l, tbl[i].ea, tbl[i].eb, tbl[i].ordy);
            #1;
            check($sformatf("vec%0d.in_ready", i), 64'(in_ready), 64'd1);
            tick();
            check_outs($sformatf("vec%0d", i), tbl[i].x_valid, tbl[i].x_out, tbl[i].x_beats);
        end

        // Backpressure: result held for 4 cycles, waiting beat not lost
        drive(1'b1, 1'b0, 1'b0, 8'h5A, 8'h00, 1'b0);
        tick();
        check_outs("bp_load", 1'b1, 8'h5A, 8'd1);
        drive(1'b1, 1'b0, 1'b0, 8'h11, 8'h22, 1'b0);
        for (int i = 0; i < 4; i++) begin
            #1;
            check($sformatf("bp%0d.in_ready", i), 64'(in_ready), 64'd0);
            tick();
            check_outs($sformatf("bp%0d", i), 1'b1, 8'h5A, 8'd1);
        end
        out_ready = 1'b1;
        #1;
        check("bp_release.in_ready", 64'(in_ready), 64'd1);
        tick();
        check_outs("bp_handoff", 1'b1, 8'h33, 8'd1);
        drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
        tick();
        check_outs("bp_drain", 1'b0, 8'h33, 8'd1);

        // Reset mid-frame discards the partial accumulation
        drive(1'b1, 1'b1, 1'b0, 8'h03, 8'h00, 1'b1);
        tick();
        drive(1'b1, 1'b1, 1'b0, 8'h0C, 8'h00, 1'b1);
        tick();
        drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
        #1;
        reset = 1'b1;
        #1;
        check_outs("async_reset", 1'b0, 8'h00, 8'h00);
        check("async_reset.in_ready", 64'(in_ready), 64'd1);
        #2;
        reset = 1'b0;
        drive(1'b1, 1'b1, 1'b1, 8'hFF, 8'h00, 1'b1);
        tick();
        check_outs("reset_midframe", 1'b1, 8'hFF, 8'd1);

        // Saturation: 300-beat frame of 0x01
        drive(1'b1, 1'b1, 1'b0, 8'h01, 8'h00, 1'b1);
        for (int i = 0; i < 299; i++) tick();
        check_outs("sat_open", 1'b0, 8'hFF, 8'd1);
        last = 1'b1;
        tick();
        check_outs("sat_close", 1'b1, 8'h00, 8'hFF);
        drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
        tick();

        // Randomized traffic against the frame-list model
        frame_q.delete();
        m_out   = 8'h00;
        m_beats = 8'h00;
        m_valid = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
        #1;
        reset = 1'b1;
        #2;
        reset = 1'b0;
        for (int c = 0; c < 600; c++) begin
            logic exp_ready;
            drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0),
                  1'($urandom_range(0, 4) == 0), 8'($urandom), 8'($urandom),
                  1'($urandom_range(0, 2) != 0));
            exp_ready = !m_valid || out_ready;
            #1;
            check($sformatf("rnd%0d.in_ready", c), 64'(in_ready), 64'(exp_ready));
            if (m_valid && out_ready) m_valid = 1'b0;
            if (in_valid && exp_ready) begin
                if (!mode) begin
                    m_out   = a ^ b;
                    m_beats = 8'd1;
                    m_valid = 1'b1;
                end else begin
                    frame_q.push_back(a ^ b);
                    if (last) begin
                        m_out   = fold_frame();
                        m_beats = (frame_q.size() > 255) ? 8'd255 : 8'(frame_q.size());
                        m_valid = 1'b1;
                        frame_q.delete();
                    end
                end
            end
            tick();
            check_outs($sformatf("rnd%0d", c), m_valid, m_out, m_beats);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
